vram_scan_arbiter: RTL
======================

Name: vram_scan_arbiter

Overview:
- Shares one single-port, synchronous-read video RAM between two users: VGA scanout (fixed-priority reads) and a pixel writer (req/ack handshake).
- The frame buffer is 160x120 cells of 3-bit RGB, each cell scaled 4x4 onto the 640x480 raster.
- Driven by the column/row counts of the VGA timing counters. Supplies the 3-bit iPixel input of the VGA controller.

Parameters:
- H_ACTIVE, 640, visible columns.
- V_ACTIVE, 480, visible rows.
- H_TOTAL, 800, columns per line, counted 0..H_TOTAL-1.
- V_TOTAL, 521, rows per frame, counted 0..V_TOTAL-1.
- FB_WIDTH, 160, frame-buffer cells per line (H_ACTIVE>>2).
- FB_HEIGHT, 120, frame-buffer lines (V_ACTIVE>>2).
- ADDR_W, 15, RAM address width.

Ports:
- Clock  in  1  system/pixel clock, all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- iEnable  in  1  1 = scanout active; 0 = no scan reads, writer owns every cycle.
- iColumn  in  10  current column count, 0..H_TOTAL-1.
- iRow  in  10  current row count, 0..V_TOTAL-1.
- iWrReq  in  1  writer request; held with addr/data stable until acked.
- iWrAddr  in  ADDR_W  cell address, row*FB_WIDTH+col.
- iWrData  in  3  cell colour {R,G,B}.
- oWrAck  out  1  write accepted this cycle.
- oRamAddr  out  ADDR_W  RAM address.
- oRamData  out  3  RAM write data.
- oRamWe  out  1  RAM write enable.
- iRamData  in  3  RAM read data, valid 1 cycle after the address is presented.
- oPixel  out  3  pixel to the VGA controller.
- oDropErr  out  1  sticky flag: an out-of-range write was acked and discarded.

Behaviour:
- Reset (synchronous): oPixel=000, internal prefetch register rNext=000, oDropErr=0. While Reset=1: oWrAck=0, oRamWe=0, oRamAddr=0.
- Scan slot: any cycle in which iEnable=1 and one of the following holds:
  - (a) iRow<V_ACTIVE, iColumn[1:0]==0 and iColumn<H_ACTIVE-4. Fetch group g=(iColumn>>2)+1 of cell line iRow>>2.
  - (b) iColumn==H_TOTAL-4 and the next row nr is below V_ACTIVE, where nr=(iRow==V_TOTAL-1)?0:iRow+1. Fetch group 0 of cell line nr>>2.
- In a scan slot: oRamAddr=line*FB_WIDTH+g (ADDR_W bits, no overflow for legal counts), oRamWe=0, oWrAck=0.
- rNext captures iRamData at the end of the cycle following every scan slot.
- oPixel register update, at the end of each cycle:
  - If iEnable=1, iRow<V_ACTIVE, iColumn<H_ACTIVE and iColumn[1:0]==0: oPixel<=rNext.
  - Else if iColumn>=H_ACTIVE, or iRow>=V_ACTIVE, or iEnable=0: oPixel<=000.
  - Otherwise oPixel holds.
  - Net latency: oPixel presents the cell for column c one cycle after iColumn=c.
- Writer slot: every non-scan cycle.
  - If iWrReq=1 and iWrAddr<FB_WIDTH*FB_HEIGHT (19200): oRamWe=1, oRamAddr=iWrAddr, oRamData=iWrData, oWrAck=1. All are combinational from inputs in that cycle.
  - If iWrReq=1 and the address is out of range: oWrAck=1, oRamWe=0, and oDropErr<=1 (stays set until Reset).
  - If iWrReq=0: oRamWe=0, oWrAck=0.
  - The writer holds its request through a scan slot; worst-case wait is 1 cycle.
- Coherency: a write to a cell already prefetched into rNext is not seen until the next frame's fetch of that cell. No bypass.
- iEnable falling mid-line: scanout stops immediately and oPixel=000 from the next cycle. On rising, output is valid from the next (b) prefetch onward. Cells before that show stale rNext or 000.
- oRamData=iWrData whenever oRamWe=0 (don't-care to RAM).
- Reset mid-frame: state clears, scanout resumes at the next (b) prefetch.

Test Plan:
- Reset held 3 cycles with iWrReq=1 -> oPixel=000, oRamWe=0, oWrAck=0, oDropErr=0.
- Write cell 0=101 during vertical blank; run to row 520 col 796 -> oRamAddr=0, oRamWe=0. At row 0, oPixel=101 for cols 1..4.
- Row 5, col 8, iEnable=1 -> oRamAddr=1*160+3=163, oRamWe=0, oWrAck=0 even with iWrReq=1.
- iWrReq held (addr 42, data 011) from row 0 col 4 -> oWrAck=0 at col 4. At col 5: oWrAck=1, oRamWe=1, oRamAddr=42, oRamData=011.
- iWrReq with iWrAddr=19200 -> oWrAck=1, oRamWe=0, oDropErr=1, still 1 after 100 cycles.
- iEnable=0 (or row 490) with back-to-back writes -> every cycle acked, no reads issued, oPixel=000.

Source files
------------

// File: rtl/vram_scan_arbiter_if.sv
// Writer handshake and single-port video RAM bus shared by the scan arbiter.
interface vram_scan_arbiter_if #(
  parameter int unsigned ADDR_W = 15
);
  logic              iWrReq;
  logic [ADDR_W-1:0] iWrAddr;
  logic [2:0]        iWrData;
  logic              oWrAck;
  logic [ADDR_W-1:0] oRamAddr;
  logic [2:0]        oRamData;
  logic              oRamWe;
  logic [2:0]        iRamData;

  modport slave (
    input  iWrReq, iWrAddr, iWrData, iRamData,
    output oWrAck, oRamAddr, oRamData, oRamWe
  );

  modport master (
    output iWrReq, iWrAddr, iWrData, iRamData,
    input  oWrAck, oRamAddr, oRamData, oRamWe
  );
endinterface

// File: rtl/vram_scan_arbiter.sv
// Arbitrates one synchronous-read video RAM between VGA scanout prefetch
// (fixed priority) and a req/ack pixel writer; 160x120 cells scaled 4x4.
module vram_scan_arbiter #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned H_TOTAL   = 800,
  parameter int unsigned V_TOTAL   = 521,
  parameter int unsigned FB_WIDTH  = H_ACTIVE >> 2,
  parameter int unsigned FB_HEIGHT = V_ACTIVE >> 2,
  parameter int unsigned ADDR_W    = 15
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                iEnable,
  input  logic [9:0]          iColumn,
  input  logic [9:0]          iRow,
  vram_scan_arbiter_if.slave  bus,
  output logic [2:0]          oPixel,
  output logic                oDropErr
);

  localparam logic [9:0]        HA       = 10'(H_ACTIVE);
  localparam logic [9:0]        HT       = 10'(H_TOTAL);
  localparam logic [9:0]        VA       = 10'(V_ACTIVE);
  localparam logic [9:0]        VT       = 10'(V_TOTAL);
  localparam logic [ADDR_W-1:0] FBW      = ADDR_W'(FB_WIDTH);
  localparam logic [ADDR_W-1:0] FB_CELLS = ADDR_W'(FB_WIDTH * FB_HEIGHT);

  logic [9:0] next_row;
  logic       slot_a, slot_b, scan;
  logic [7:0] line, grp;
  logic       drop;
  logic       pend_q;
  logic [2:0] rnext_q;

  // Slot (a) fetches the group one ahead of the column being shown; slot (b)
  // fetches group 0 of the coming line near the end of horizontal blanking.
  always_comb begin
    next_row = (iRow == VT - 10'd1) ? '0 : iRow + 10'd1;
    slot_a   = iEnable && (iRow < VA) && (iColumn[1:0] == 2'b00) && (iColumn < HA - 10'd4);
    slot_b   = iEnable && (iColumn == HT - 10'd4) && (next_row < VA);
    scan     = slot_a || slot_b;
    line     = slot_b ? next_row[9:2] : iRow[9:2];
    grp      = slot_b ? '0 : iColumn[9:2] + 8'd1;
  end

  always_comb begin
    bus.oRamAddr = '0;
    bus.oRamWe   = 1'b0;
    bus.oWrAck   = 1'b0;
    bus.oRamData = bus.iWrData;
    drop         = 1'b0;
    if (!Reset) begin
      if (scan) begin
        bus.oRamAddr = ADDR_W'(line) * FBW + ADDR_W'(grp);
      end else if (bus.iWrReq) begin
        bus.oWrAck = 1'b1;
        if (bus.iWrAddr < FB_CELLS) begin
          bus.oRamWe   = 1'b1;
          bus.oRamAddr = bus.iWrAddr;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pend_q   <= 1'b0;
      rnext_q  <= '0;
      oPixel   <= '0;
      oDropErr <= 1'b0;
    end else begin
      pend_q <= scan;
      if (pend_q) begin
        rnext_q <= bus.iRamData;
      end
      if (iEnable && (iRow < VA) && (iColumn < HA) && (iColumn[1:0] == 2'b00)) begin
        oPixel <= rnext_q;
      end else if ((iColumn >= HA) || (iRow >= VA) || !iEnable) begin
        oPixel <= '0;
      end
      if (drop) begin
        oDropErr <= 1'b1;
      end
    end
  end

endmodule
